// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: register map, status/control bit positions and FSM encodings
package uart_fifo_pkg;
   localparam logic [1:0] c_addr_data = 2'd0;
   localparam logic [1:0] c_addr_stat = 2'd1;
   localparam logic [1:0] c_addr_divl = 2'd2;
   localparam logic [1:0] c_addr_divh = 2'd3;
   localparam int c_st_rx_ne   = 0;
   localparam int c_st_tx_nf   = 1;
   localparam int c_st_ovr     = 2;
   localparam int c_st_fe      = 3;
   localparam int c_st_tx_idle = 4;
   localparam int c_st_irq     = 7;
   localparam int c_ct_rx_ie = 0;
   localparam int c_ct_tx_ie = 1;
   localparam int c_ct_clr   = 7;
   localparam logic [1:0] c_rx_idle  = 2'd0;
   localparam logic [1:0] c_rx_start = 2'd1;
   localparam logic [1:0] c_rx_data  = 2'd2;
   localparam logic [1:0] c_rx_stop  = 2'd3;
   localparam logic [1:0] c_tx_idle  = 2'd0;
   localparam logic [1:0] c_tx_start = 2'd1;
   localparam logic [1:0] c_tx_data  = 2'd2;
   localparam logic [1:0] c_tx_stop  = 2'd3;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO; full/empty from the extra pointer MSB,
// pushes while full and pops while empty are ignored
module uart_sync_fifo #(
   parameter int width = 8,
   parameter int depth = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [width-1:0] head
);
   localparam int aw = $clog2(depth);
   logic [aw:0] wp_q, wp_d, rp_q, rp_d;
   logic [width-1:0] mem_q [depth];
   logic do_push, do_pop;
   assign empty   = wp_q == rp_q;
   assign full    = (wp_q[aw] != rp_q[aw]) && (wp_q[aw-1:0] == rp_q[aw-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wp_d    = wp_q + {{aw{1'b0}}, do_push};
   assign rp_d    = rp_q + {{aw{1'b0}}, do_pop};
   assign head    = mem_q[rp_q[aw-1:0]];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q[aw-1:0]] <= din;
   end
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: byte UART with TX/RX FIFOs, programmable baud divisor, CTS flow
// control and a level interrupt, behind a 4-register bus
module uart_fifo
   import uart_fifo_pkg::*;
#(
   parameter int          c_fifo_depth = 16,
   parameter logic [15:0] c_reset_div  = 16'd163,
   parameter int          c_oversample = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs,
   input  logic       wr,
   input  logic       rd,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       rxd,
   output logic       txd,
   input  logic       cts_n,
   output logic       irq
);
   localparam int ow = $clog2(c_oversample);
   logic [15:0] div_q, div_d, baud_q, baud_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d;
   logic rx_s1_q, rx_s2_q;
   logic [1:0] rx_st_q, rx_st_d, tx_st_q, tx_st_d;
   logic [ow-1:0] rx_tc_q, rx_tc_d, tx_tc_q, tx_tc_d;
   logic [2:0] rx_bc_q, rx_bc_d, tx_bc_q, tx_bc_d;
   logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
   logic tick, wr_en, rd_en, err_clr, ovr_set, fe_set, tx_idle;
   logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0] tx_head, rx_head, stat;
   uart_sync_fifo #(.width(8), .depth(c_fifo_depth)) u_tx_fifo (
      .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .din(din),
      .full(tx_full), .empty(tx_empty), .head(tx_head)
   );
   uart_sync_fifo #(.width(8), .depth(c_fifo_depth)) u_rx_fifo (
      .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
      .full(rx_full), .empty(rx_empty), .head(rx_head)
   );
   assign wr_en   = cs && wr;
   assign rd_en   = cs && rd;
   assign tx_push = wr_en && addr == c_addr_data;
   assign rx_pop  = rd_en && addr == c_addr_data;
   assign err_clr = wr_en && addr == c_addr_stat && din[c_ct_clr];
   assign tick    = baud_q == 16'd0;
   // a divisor of 0 behaves like 1 so the tick never stalls
   assign baud_d  = tick ? ((div_q == 16'd0) ? 16'd0 : div_q - 16'd1) : baud_q - 16'd1;
   assign div_d   = {(wr_en && addr == c_addr_divh) ? din : div_q[15:8],
                     (wr_en && addr == c_addr_divl) ? din : div_q[7:0]};
   assign ctrl_d  = (wr_en && addr == c_addr_stat) ? {din[c_ct_tx_ie], din[c_ct_rx_ie]} : ctrl_q;
   assign ovr_d   = ovr_set || (ovr_q && !err_clr);
   assign fe_d    = fe_set || (fe_q && !err_clr);
   assign irq_d   = (ctrl_q[c_ct_rx_ie] && !rx_empty) || (ctrl_q[c_ct_tx_ie] && tx_empty) || ovr_q || fe_q;
   assign tx_idle = tx_empty && tx_st_q == c_tx_idle;
   assign irq     = irq_q;
   assign txd     = (tx_st_q == c_tx_start) ? 1'b0 : (tx_st_q == c_tx_data) ? tx_sh_q[0] : 1'b1;
   always_comb begin
      stat               = '0;
      stat[c_st_rx_ne]   = !rx_empty;
      stat[c_st_tx_nf]   = !tx_full;
      stat[c_st_ovr]     = ovr_q;
      stat[c_st_fe]      = fe_q;
      stat[c_st_tx_idle] = tx_idle;
      stat[c_st_irq]     = irq_q;
   end
   assign dout = (addr == c_addr_data) ? (rx_empty ? 8'h00 : rx_head) :
                 (addr == c_addr_stat) ? stat :
                 (addr == c_addr_divl) ? div_q[7:0] : div_q[15:8];
   always_comb begin
      rx_st_d = rx_st_q;
      rx_tc_d = rx_tc_q;
      rx_bc_d = rx_bc_q;
      rx_sh_d = rx_sh_q;
      rx_push = 1'b0;
      ovr_set = 1'b0;
      fe_set  = 1'b0;
      case (rx_st_q)
         c_rx_idle: begin
            rx_tc_d = '0;
            rx_bc_d = '0;
            if (!rx_s2_q) rx_st_d = c_rx_start;
         end
         c_rx_start: if (tick) begin
            rx_tc_d = rx_tc_q + ow'(1);
            if (rx_tc_q == ow'(c_oversample / 2 - 1)) begin
               rx_tc_d = '0;
               rx_st_d = rx_s2_q ? c_rx_idle : c_rx_data;
            end
         end
         c_rx_data: if (tick) begin
            rx_tc_d = rx_tc_q + ow'(1);
            if (&rx_tc_q) begin
               rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
               rx_bc_d = rx_bc_q + 3'd1;
               if (&rx_bc_q) rx_st_d = c_rx_stop;
            end
         end
         default: if (tick) begin
            rx_tc_d = rx_tc_q + ow'(1);
            if (&rx_tc_q) begin
               rx_st_d = c_rx_idle;
               fe_set  = !rx_s2_q;
               ovr_set = rx_s2_q && rx_full;
               rx_push = rx_s2_q && !rx_full;
            end
         end
      endcase
   end
   always_comb begin
      tx_st_d = tx_st_q;
      tx_tc_d = tx_tc_q;
      tx_bc_d = tx_bc_q;
      tx_sh_d = tx_sh_q;
      tx_pop  = 1'b0;
      case (tx_st_q)
         c_tx_idle: begin
            tx_tc_d = '0;
            tx_bc_d = '0;
            if (!tx_empty && !cts_n) begin
               tx_pop  = 1'b1;
               tx_sh_d = tx_head;
               tx_st_d = c_tx_start;
            end
         end
         c_tx_start: if (tick) begin
            tx_tc_d = tx_tc_q + ow'(1);
            if (&tx_tc_q) tx_st_d = c_tx_data;
         end
         c_tx_data: if (tick) begin
            tx_tc_d = tx_tc_q + ow'(1);
            if (&tx_tc_q) begin
               tx_sh_d = {1'b0, tx_sh_q[7:1]};
               tx_bc_d = tx_bc_q + 3'd1;
               if (&tx_bc_q) tx_st_d = c_tx_stop;
            end
         end
         default: if (tick) begin
            tx_tc_d = tx_tc_q + ow'(1);
            if (&tx_tc_q) tx_st_d = c_tx_idle;
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= c_reset_div;
         baud_q  <= '0;
         ctrl_q  <= '0;
         ovr_q   <= 1'b0;
         fe_q    <= 1'b0;
         irq_q   <= 1'b0;
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_st_q <= c_rx_idle;
         rx_tc_q <= '0;
         rx_bc_q <= '0;
         rx_sh_q <= '0;
         tx_st_q <= c_tx_idle;
         tx_tc_q <= '0;
         tx_bc_q <= '0;
         tx_sh_q <= '0;
      end else begin
         div_q   <= div_d;
         baud_q  <= baud_d;
         ctrl_q  <= ctrl_d;
         ovr_q   <= ovr_d;
         fe_q    <= fe_d;
         irq_q   <= irq_d;
         rx_s1_q <= rxd;
         rx_s2_q <= rx_s1_q;
         rx_st_q <= rx_st_d;
         rx_tc_q <= rx_tc_d;
         rx_bc_q <= rx_bc_d;
         rx_sh_q <= rx_sh_d;
         tx_st_q <= tx_st_d;
         tx_tc_q <= tx_tc_d;
         tx_bc_q <= tx_bc_d;
         tx_sh_q <= tx_sh_d;
      end
   end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for uart_fifo at divisor 1 (16-cycle bits)
module tb_uart_fifo;
   logic clk = 1'b0, reset_n = 1'b0, cs = 1'b0, wr = 1'b0, rd = 1'b0, rxd = 1'b1, cts_n = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'h00, dout, v;
   logic txd, irq;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   uart_fifo dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
      .din(din), .dout(dout), .rxd(rxd), .txd(txd), .cts_n(cts_n), .irq(irq)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; din = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask
   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1 d = dout;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
   endtask
   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
      rxd = stop;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
   endtask
   task automatic tx_frame(input string tag, input logic [7:0] exp);
      int n = 0;
      logic [7:0] b;
      while (txd !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start_seen"}, {7'd0, 1'(n < 1000)}, 8'd1);
      repeat (8) @(negedge clk);
      chk({tag, "_start_bit"}, {7'd0, txd}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clk);
         b[i] = txd;
      end
      chk({tag, "_data"}, b, exp);
      repeat (16) @(negedge clk);
      chk({tag, "_stop_bit"}, {7'd0, txd}, 8'd1);
   endtask
   initial begin
      int n, lows;
      repeat (3) @(negedge clk);
      chk("rst_txd", {7'd0, txd}, 8'd1);
      chk("rst_irq", {7'd0, irq}, 8'd0);
      reset_n = 1'b1;
      addr = 2'd1; #1 chk("rst_stat", dout, 8'h12);
      addr = 2'd2; #1 chk("rst_divl", dout, 8'hA3);
      addr = 2'd3; #1 chk("rst_divh", dout, 8'h00);
      wr_reg(2'd2, 8'h01);
      rd_reg(2'd2, v); chk("divl_rb", v, 8'h01);
      repeat (200) @(negedge clk);
      rd_reg(2'd0, v); chk("empty_rd", v, 8'h00);
      rd_reg(2'd1, v); chk("empty_rd_stat", v, 8'h12);
      // single transmit frame
      wr_reg(2'd0, 8'h55);
      tx_frame("tx55", 8'h55);
      repeat (20) @(negedge clk);
      rd_reg(2'd1, v); chk("tx_idle_after", v, 8'h12);
      // tx interrupt enable
      wr_reg(2'd1, 8'h02);
      repeat (2) @(negedge clk);
      chk("tx_irq_on", {7'd0, irq}, 8'd1);
      wr_reg(2'd1, 8'h00);
      repeat (2) @(negedge clk);
      chk("tx_irq_off", {7'd0, irq}, 8'd0);
      // single receive frame
      send_byte(8'hA3, 1'b1);
      rd_reg(2'd1, v); chk("rx_stat_ne", v, 8'h13);
      wr_reg(2'd1, 8'h01);
      repeat (2) @(negedge clk);
      chk("rx_irq_on", {7'd0, irq}, 8'd1);
      wr_reg(2'd1, 8'h00);
      rd_reg(2'd0, v); chk("rx_data", v, 8'hA3);
      rd_reg(2'd1, v); chk("rx_stat_empty", v, 8'h12);
      // overrun: 17 frames into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send_byte(8'h30 + 8'(i), 1'b1);
      rd_reg(2'd1, v); chk("ovr_stat", v, 8'h97);
      chk("ovr_irq", {7'd0, irq}, 8'd1);
      for (int i = 0; i < 16; i++) begin
         rd_reg(2'd0, v); chk("ovr_readback", v, 8'h30 + 8'(i));
      end
      rd_reg(2'd1, v); chk("ovr_drained", v, 8'h96);
      wr_reg(2'd1, 8'h80);
      repeat (2) @(negedge clk);
      rd_reg(2'd1, v); chk("ovr_cleared", v, 8'h12);
      chk("ovr_irq_clr", {7'd0, irq}, 8'd0);
      // framing error and glitch rejection
      send_byte(8'h5A, 1'b0);
      repeat (40) @(negedge clk);
      rd_reg(2'd1, v); chk("fe_stat", v, 8'h9A);
      wr_reg(2'd1, 8'h80);
      @(negedge clk);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      rd_reg(2'd1, v); chk("glitch_stat", v, 8'h12);
      // flow control: fill TX while blocked, then drain
      cts_n = 1'b1;
      for (int i = 0; i < 20; i++) wr_reg(2'd0, 8'(i));
      repeat (40) @(negedge clk);
      rd_reg(2'd1, v); chk("tx_full_stat", v, 8'h00);
      chk("tx_blocked_txd", {7'd0, txd}, 8'd1);
      cts_n = 1'b0;
      for (int i = 0; i < 16; i++) tx_frame("txq", 8'(i));
      lows = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      chk("tx_no_extra", 8'(lows), 8'd0);
      rd_reg(2'd1, v); chk("tx_drained_stat", v, 8'h12);
      // asynchronous reset in mid-frame
      wr_reg(2'd1, 8'h02);
      wr_reg(2'd2, 8'h07);
      wr_reg(2'd2, 8'h01);
      repeat (200) @(negedge clk);
      wr_reg(2'd0, 8'h3C);
      n = 0;
      while (txd !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      chk("pre_rst_txd", {7'd0, txd}, 8'd0);
      #2 reset_n = 1'b0;
      #1 chk("arst_txd", {7'd0, txd}, 8'd1);
      chk("arst_irq", {7'd0, irq}, 8'd0);
      addr = 2'd2; #1 chk("arst_divl", dout, 8'hA3);
      addr = 2'd3; #1 chk("arst_divh", dout, 8'h00);
      addr = 2'd1; #1 chk("arst_stat", dout, 8'h12);
      @(negedge clk);
      reset_n = 1'b1;
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      chk("post_rst_quiet", 8'(lows), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter c_fifo_depth, default 16, is the TX and RX FIFO depth in bytes; it SHALL be a power of 2 from 2 to 256.
REQ-002 Parameter c_reset_div, default 163, is the reset value of the 16-bit baud divisor (25 MHz / (16 x 9600)).
REQ-003 Parameter c_oversample, default 16, is the number of baud ticks per bit; it SHALL be a power of 2 of at least 8.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 Port cs, input, 1 bit: chip select.
REQ-007 Port wr, input, 1 bit: one-cycle write strobe, qualified by cs.
REQ-008 Port rd, input, 1 bit: one-cycle read strobe, qualified by cs.
REQ-009 Port addr, input, 2 bits: register select.
REQ-010 Port din, input, 8 bits: write data.
REQ-011 Port dout, output, 8 bits: read data; combinational from addr and the current state.
REQ-012 Port rxd, input, 1 bit: asynchronous serial input.
REQ-013 Port txd, output, 1 bit: serial output.
REQ-014 Port cts_n, input, 1 bit: clear-to-send, active-low.
REQ-015 Port irq, output, 1 bit: interrupt request, active-high, level.

Function
REQ-016 The register map SHALL be:
- addr 0, write: push the TX FIFO.
- addr 0, read: RX FIFO head; the rd strobe pops it.
- addr 1, read: status.
- addr 1, write: control.
- addr 2: divisor bits [7:0], read/write.
- addr 3: divisor bits [15:8], read/write.
REQ-017 Status bits SHALL be:
- bit0 rx_not_empty
- bit1 tx_not_full
- bit2 overrun
- bit3 framing_err
- bit4 tx_idle (TX FIFO empty and transmitter in IDLE)
- bit7 irq
- all other bits 0
REQ-018 Control bits SHALL be:
- bit0 rx_irq_en
- bit1 tx_irq_en
- bit7 is write-1-to-clear for both overrun and framing_err and is not stored
REQ-019 A write to addr 0 while the TX FIFO is full SHALL be dropped, with no state change.
REQ-020 A read of addr 0 while the RX FIFO is empty SHALL return 0x00 and SHALL NOT pop.
REQ-021 A FIFO push and pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-022 Baud tick: a counter reloads with max(divisor,1)-1 and emits a one-cycle tick when it reaches 0.
REQ-023 A divisor write SHALL take effect at the next counter reload.
REQ-024 rxd SHALL pass a 2-flop synchronizer, and the synchronizer SHALL reset to 1.
REQ-025 RX FSM transitions SHALL be:
- IDLE -> START on a low synchronized rxd.
- START: if the sample at tick c_oversample/2 is still low -> DATA, otherwise -> IDLE (glitch rejected).
- DATA samples 8 bits, LSB first, every c_oversample ticks -> STOP.
- STOP samples once more -> IDLE.
REQ-026 At STOP, if the sample is 0: set framing_err and discard the byte.
REQ-027 At STOP, if the sample is 1 and the RX FIFO is full: set overrun and discard the byte.
REQ-028 At STOP, otherwise: push the byte.
REQ-029 TX FSM transitions SHALL be:
- IDLE -> START when the TX FIFO is not empty and cts_n=0, popping one byte.
- START, DATA (8 bits, LSB first) and STOP each hold txd for c_oversample ticks per bit.
- STOP -> IDLE.
REQ-030 cts_n is sampled only in IDLE; a byte already in progress SHALL complete.
REQ-031 irq SHALL equal (rx_irq_en AND rx_not_empty) OR (tx_irq_en AND TX FIFO empty) OR overrun OR framing_err, registered with 1-cycle latency.
REQ-032 If an error clear and an error set occur in the same cycle, the set SHALL win.
REQ-033 FIFO pointers SHALL be log2(c_fifo_depth)+1 bits wide; full and empty SHALL be decided by MSB comparison and wrap naturally.

Reset
REQ-034 On reset_n low, the following SHALL take their reset values immediately:
- txd=1, irq=0
- both FIFOs empty
- divisor=c_reset_div, control=0, overrun=0, framing_err=0
- both FSMs in IDLE, baud counter=0
REQ-035 Reset asserted in the middle of a byte SHALL abort it, with txd high in the same cycle.
REQ-036 Deassertion of reset_n SHALL be the only reset event; there is no software reset.

Structure
REQ-037 Package uart_fifo_pkg SHALL hold:
- the register address constants
- the status and control bit indices
- the RX and TX FSM state encodings
REQ-038 Sub-module uart_sync_fifo (parameters width and depth; push, pop, full, empty, head) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-039 After reset, divisor=1, tx_irq_en=0: write 0x55 to addr 0 -> txd shows start 0, then bits 1,0,1,0,1,0,1,0, then stop 1, each bit 16 cycles; tx_idle reads 1 afterwards.
REQ-040 Drive rxd with 0xA3 at divisor 1 (16-cycle bits), then read addr 1 and addr 0 -> status bit0 =1, addr 0 returns 0xA3, then status bit0 =0.
REQ-041 Send 17 bytes into RX with c_fifo_depth=16 -> overrun=1 and irq=1; the 16 stored bytes read back in order; writing 0x80 to addr 1 clears overrun and irq.
REQ-042 Send a frame with stop bit 0 -> framing_err=1 and the RX FIFO stays empty; a 4-cycle low glitch on rxd -> nothing received.
REQ-043 Push 20 bytes with cts_n=1 -> 16 accepted and status bit1 =0; release cts_n -> exactly 16 frames transmitted.
REQ-044 Assert reset_n low mid-transmission -> txd=1 asynchronously, divisor reads back 163, status reads 0x12.
